// File: rtl/query_row_buffer_ctrl.sv
// Ping-pong sequencer for the query row double buffer: steers writes into the fill bank,
// drains the full bank through the RAM read port and tracks per-bank full status.
module query_row_buffer_ctrl #(
   parameter int unsigned ADDR_WIDTH   = 7,
   parameter int unsigned DEPTH        = 128,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fsm_enable,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [ADDR_WIDTH-1:0] wadr,
   output logic                  wbank,
   input  logic                  rd_start,
   output logic                  ren,
   output logic [ADDR_WIDTH-1:0] radr,
   output logic                  rbank,
   output logic                  rdata_valid,
   output logic                  row_done,
   output logic [1:0]            bank_full,
   output logic                  overflow_err
);

   localparam int unsigned            CW       = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [ADDR_WIDTH-1:0]  LAST_ADR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [CW-1:0]          CNT_INIT = CW'(READ_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   wadr_q, wadr_d;
   logic [ADDR_WIDTH-1:0]   radr_q, radr_d;
   logic                    wbank_q, wbank_d;
   logic                    rbank_q, rbank_d;
   logic [1:0]              bank_full_q, bank_full_d;
   logic                    ovf_q, ovf_d;
   logic                    pend_q, pend_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [READ_LATENCY-1:0] vshift_q, vshift_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wadr_q      <= '0;
         radr_q      <= '0;
         wbank_q     <= 1'b0;
         rbank_q     <= 1'b0;
         bank_full_q <= '0;
         ovf_q       <= 1'b0;
         pend_q      <= 1'b0;
         cnt_q       <= '0;
         vshift_q    <= '0;
      end else begin
         state_q     <= state_d;
         wadr_q      <= wadr_d;
         radr_q      <= radr_d;
         wbank_q     <= wbank_d;
         rbank_q     <= rbank_d;
         bank_full_q <= bank_full_d;
         ovf_q       <= ovf_d;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         vshift_q    <= vshift_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wadr_d      = wadr_q;
      radr_d      = radr_q;
      wbank_d     = wbank_q;
      rbank_d     = rbank_q;
      bank_full_d = bank_full_q;
      ovf_d       = ovf_q;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      ren         = 1'b0;
      row_done    = 1'b0;
      wr_ready    = fsm_enable & ~bank_full_q[wbank_q];

      if (wr_valid && wr_ready) begin
         if (wadr_q == LAST_ADR) begin
            bank_full_d[wbank_q] = 1'b1;
            wbank_d              = ~wbank_q;
            wadr_d               = '0;
         end else begin
            wadr_d = wadr_q + ADDR_WIDTH'(1);
         end
      end
      if (wr_valid && fsm_enable && !wr_ready) begin
         ovf_d = 1'b1;
      end
      if (rd_start) begin
         pend_d = 1'b1;
      end

      // Write- and read-completion always hit opposite banks, so both bit updates stand.
      unique case (state_q)
         S_IDLE: begin
            if (fsm_enable && (pend_q || rd_start) && bank_full_q[rbank_q]) begin
               state_d = S_READ;
               radr_d  = '0;
               pend_d  = 1'b0;
            end
         end
         S_READ: begin
            if (fsm_enable) begin
               ren = 1'b1;
               if (radr_q == LAST_ADR) begin
                  state_d = S_DRAIN;
                  cnt_d   = CNT_INIT;
                  radr_d  = '0;
               end else begin
                  radr_d = radr_q + ADDR_WIDTH'(1);
               end
            end
         end
         S_DRAIN: begin
            if (cnt_q == '0) begin
               row_done             = 1'b1;
               bank_full_d[rbank_q] = 1'b0;
               rbank_d              = ~rbank_q;
               state_d              = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      vshift_d = (vshift_q << 1) | READ_LATENCY'(ren);
   end

   assign wadr         = wadr_q;
   assign wbank        = wbank_q;
   assign radr         = radr_q;
   assign rbank        = rbank_q;
   assign bank_full    = bank_full_q;
   assign overflow_err = ovf_q;
   assign rdata_valid  = vshift_q[READ_LATENCY-1];

endmodule
